div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default DATA_WIDTH (32, from package defines), operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start_i  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port DivOp_i  input  div_op_e  operation select: DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU.
REQ-006 SHALL have port operand1_i  input  WIDTH  dividend.
REQ-007 SHALL have port operand2_i  input  WIDTH  divisor.
REQ-008 SHALL have port result_o  output  WIDTH  quotient or remainder per latched op.
REQ-009 SHALL have port busy_o  output  1  high while not in IDLE.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse, result_o valid.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE.
REQ-012 IDLE with start_i=1 at an edge: latch DivOp_i and operands, next state CALC (or DONE per REQ-017/018); start_i=0: stay IDLE.
REQ-013 CALC: restoring division, one quotient bit per cycle on magnitudes, 6-bit iteration counter; after exactly WIDTH iterations go to DONE.
REQ-014 Normal latency: start_i high in cycle 0 -> done_o high in cycle WIDTH+1 (cycle 33 for WIDTH=32).
REQ-015 DONE: done_o=1 for exactly one cycle, then unconditionally IDLE.
REQ-016 Signed ops (DIV/REM): operate on absolute values; quotient negated iff operand signs differ; remainder takes dividend sign (RISC-V truncation semantics).
REQ-017 Divisor zero: skip CALC, DONE in cycle 1; DIV/DIVU result 32'hFFFFFFFF, REM/REMU result = dividend.
REQ-018 Signed overflow (DIV/REM, dividend 32'h80000000, divisor 32'hFFFFFFFF): skip CALC, DONE in cycle 1; DIV result 32'h80000000, REM result 0.
REQ-019 start_i while busy_o=1 (including the DONE cycle) SHALL be ignored; no queuing.
REQ-020 Operand/DivOp_i changes after acceptance SHALL not affect the in-flight result.
REQ-021 result_o SHALL hold its last value from the DONE cycle until the next DONE cycle.
REQ-022 Back-to-back: start_i in the cycle after done_o is accepted normally.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, result_o=0, busy_o=0, done_o=0, counter=0, regardless of state (mid-CALC aborts with no done_o).
REQ-024 rst SHALL have priority over start_i in the same cycle.

Structure
REQ-025 div_op_e (2-bit enum) SHALL be added to package defines beside alu_control_e; DATA_WIDTH reused from there.
REQ-026 SHALL be a single module with no sub-modules; sign fix-up and special-case detection inline combinational.

Verification
REQ-027 DIVU 100/7 -> done_o in cycle 33, result_o=14; REMU same operands -> 2.
REQ-028 DIV -20/3 -> 32'hFFFFFFFA (-6); REM -20/3 -> 32'hFFFFFFFE (-2); DIV 20/-3 -> -6.
REQ-029 DIV 5/0 -> done_o in cycle 1, result_o=32'hFFFFFFFF; REMU 5/0 -> 5.
REQ-030 DIV 32'h80000000/32'hFFFFFFFF -> done_o cycle 1, result_o=32'h80000000; REM -> 0.
REQ-031 Assert rst at cycle 10 of DIVU 1000/10 -> busy_o=0, result_o=0 next cycle, no done_o; start_i pulses during busy ignored (single done_o).
REQ-032 Back-to-back DIVU 9/3 then REMU 10/4 with start_i the cycle after done_o -> results 3 then 2, each exactly one done_o pulse.

Source files
------------

// File: rtl/defines.sv
// ----------------------------------------------------------------------------
// defines
//   Shared type and width definitions for the execution units.
//   DATA_WIDTH    : native datapath width in bits.
//   alu_control_e : ALU operation select.
//   div_op_e      : divider operation select (signed/unsigned, quotient/remainder).
// ----------------------------------------------------------------------------
package defines;

   localparam int DATA_WIDTH = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_control_e;

   typedef enum logic [1:0] {
      DIV_DIV  = 2'd0,
      DIV_DIVU = 2'd1,
      DIV_REM  = 2'd2,
      DIV_REMU = 2'd3
   } div_op_e;

endpackage

// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit
//   Iterative restoring divider, one quotient bit per cycle, RISC-V semantics.
//   Ports:
//     clk        : system clock, rising edge
//     rst        : synchronous active-high reset
//     start_i    : request a division (accepted only when idle)
//     DivOp_i    : DIV_DIV / DIV_DIVU / DIV_REM / DIV_REMU
//     operand1_i : dividend
//     operand2_i : divisor
//     result_o   : quotient or remainder, held until the next completion
//     busy_o     : high while a request is in flight (including DONE cycle)
//     done_o     : one-cycle pulse, result_o valid
// ----------------------------------------------------------------------------
import defines::*;

module div_unit #(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  div_op_e          DivOp_i,
   input  logic [WIDTH-1:0] operand1_i,
   input  logic [WIDTH-1:0] operand2_i,
   output logic [WIDTH-1:0] result_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_result;
   logic               r_busy;
   logic               r_done;

   // In-flight operation context, captured on acceptance
   logic               r_is_rem;
   logic               r_neg_q;
   logic               r_neg_r;
   logic [WIDTH-1:0]   r_divisor;
   logic [WIDTH-1:0]   r_quot;   // shifts dividend bits out, quotient bits in
   logic [WIDTH-1:0]   r_rem;

   // Request decode, sign handling and special cases
   logic               w_signed;
   logic               w_is_rem;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic               w_div_zero;
   logic               w_ovf;
   logic [WIDTH-1:0]   w_special;

   always_comb begin
      w_signed   = (DivOp_i == DIV_DIV) || (DivOp_i == DIV_REM);
      w_is_rem   = (DivOp_i == DIV_REM) || (DivOp_i == DIV_REMU);
      w_a_neg    = w_signed && operand1_i[WIDTH-1];
      w_b_neg    = w_signed && operand2_i[WIDTH-1];
      w_a_mag    = w_a_neg ? (~operand1_i + 1'b1) : operand1_i;
      w_b_mag    = w_b_neg ? (~operand2_i + 1'b1) : operand2_i;
      w_div_zero = (operand2_i == '0);
      // Most-negative / -1 is the only signed quotient that does not fit
      w_ovf      = w_signed && (operand1_i == {1'b1, {(WIDTH-1){1'b0}}})
                   && (operand2_i == '1);
      w_special  = '0;
      if (w_div_zero) begin
         w_special = w_is_rem ? operand1_i : '1;
      end else if (w_ovf) begin
         w_special = w_is_rem ? '0 : operand1_i;
      end
   end

   // One restoring step: shift in the next dividend bit, trial-subtract
   logic [WIDTH:0]     w_rem_shift;
   logic [WIDTH:0]     w_diff;
   logic               w_fits;
   logic [WIDTH-1:0]   w_rem_next;
   logic [WIDTH-1:0]   w_quot_next;
   logic [WIDTH-1:0]   w_final;

   always_comb begin
      w_rem_shift = {r_rem, r_quot[WIDTH-1]};
      w_diff      = w_rem_shift - {1'b0, r_divisor};
      w_fits      = ~w_diff[WIDTH];
      // A restored partial remainder is always below the divisor, so W bits suffice
      w_rem_next  = w_fits ? w_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
      w_quot_next = {r_quot[WIDTH-2:0], w_fits};
      if (r_is_rem) begin
         w_final = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
      end else begin
         w_final = r_neg_q ? (~w_quot_next + 1'b1) : w_quot_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_result <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start_i) begin
                  r_busy    <= 1'b1;
                  r_is_rem  <= w_is_rem;
                  r_neg_q   <= w_a_neg ^ w_b_neg;
                  r_neg_r   <= w_a_neg;
                  r_divisor <= w_b_mag;
                  r_quot    <= w_a_mag;
                  r_rem     <= '0;
                  r_cnt     <= '0;
                  if (w_div_zero || w_ovf) begin
                     r_result <= w_special;
                     r_done   <= 1'b1;
                     r_state  <= S_DONE;
                  end else begin
                     r_state  <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_quot <= w_quot_next;
               r_rem  <= w_rem_next;
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(WIDTH - 1)) begin
                  r_result <= w_final;
                  r_done   <= 1'b1;
                  r_cnt    <= '0;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign result_o = r_result;
   assign busy_o   = r_busy;
   assign done_o   = r_done;

endmodule

// File: tb/tb_div_unit.sv
import defines::*;

module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   div_op_e     DivOp_i;
   logic [31:0] operand1_i;
   logic [31:0] operand2_i;
   logic [31:0] result_o;
   logic        busy_o;
   logic        done_o;

   div_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .DivOp_i    (DivOp_i),
      .operand1_i (operand1_i),
      .operand2_i (operand2_i),
      .result_o   (result_o),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      int          issue;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Monitor: every done_o pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && done_o) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: got done_o=1 at cycle %0d expected no pulse", cyc);
         end else begin
            mon_e = sb.pop_front();
            check32(mon_e.name, result_o, mon_e.res);
            check_int({mon_e.name, "_lat"}, cyc - mon_e.issue, mon_e.lat);
         end
      end
   end

   // Called just after a negedge; start_i is sampled at the following posedge
   task automatic issue(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat, input string name,
                        input bit expect_it);
      start_i    = 1'b1;
      DivOp_i    = op;
      operand1_i = a;
      operand2_i = b;
      if (expect_it) sb.push_back('{res, cyc, lat, name});
      @(negedge clk);
      start_i    = 1'b0;
   endtask

   // Wait for done_o, then step to the cycle after it
   task automatic wait_done(input string name);
      int k;
      for (k = 0; k < 100; k++) begin
         if (done_o) break;
         @(negedge clk);
      end
      if (k == 100) begin
         n_checks++;
         $display("FAIL %s_timeout: got no done_o in 100 cycles expected one", name);
      end
      @(negedge clk);
   endtask

   task automatic run(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input int lat, input string name);
      issue(op, a, b, res, lat, name, 1'b1);
      wait_done(name);
   endtask

   initial begin
      rst        = 1'b1;
      start_i    = 1'b0;
      DivOp_i    = DIV_DIVU;
      operand1_i = '0;
      operand2_i = '0;
      repeat (3) @(negedge clk);
      check32("rst_result", result_o, 32'h0);
      check32("rst_busy",   {31'd0, busy_o}, 32'h0);
      check32("rst_done",   {31'd0, done_o}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      run(DIV_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
      run(DIV_REMU, 32'd100, 32'd7, 32'd2,  33, "remu_100_7");
      run(DIV_DIV,  -32'sd20, 32'd3, 32'hFFFFFFFA, 33, "div_m20_3");
      run(DIV_REM,  -32'sd20, 32'd3, 32'hFFFFFFFE, 33, "rem_m20_3");
      run(DIV_DIV,  32'd20, -32'sd3, 32'hFFFFFFFA, 33, "div_20_m3");
      run(DIV_REM,  32'd20, -32'sd3, 32'd2,        33, "rem_20_m3");
      run(DIV_DIVU, 32'hFFFFFFFF, 32'd1,  32'hFFFFFFFF, 33, "divu_max_1");
      run(DIV_REMU, 32'hFFFFFFFF, 32'h10, 32'hF,        33, "remu_max_16");
      run(DIV_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h0,  33, "divu_min_max");
      run(DIV_DIV,  32'd5, 32'd0, 32'hFFFFFFFF, 1, "div_5_0");
      run(DIV_REMU, 32'd5, 32'd0, 32'd5,        1, "remu_5_0");
      run(DIV_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "divu_5_0");
      run(DIV_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
      run(DIV_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0,        1, "rem_ovf");

      // Start held high through busy (incl. DONE cycle) with new operands
      issue(DIV_DIVU, 32'd77, 32'd7, 32'd11, 33, "divu_busy_ign", 1'b1);
      start_i    = 1'b1;
      DivOp_i    = DIV_REMU;
      operand1_i = 32'd1000;
      operand2_i = 32'd3;
      for (int k = 0; k < 100; k++) begin
         if (done_o) break;
         @(negedge clk);
      end
      @(posedge clk);
      #1 start_i = 1'b0;
      repeat (40) @(negedge clk);
      check32("busy_after_ign", {31'd0, busy_o}, 32'h0);

      // Reset mid-calculation aborts with no done_o
      issue(DIV_DIVU, 32'd1000, 32'd10, 32'd0, 0, "divu_abort", 1'b0);
      repeat (9) @(negedge clk);
      check32("busy_before_rst", {31'd0, busy_o}, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      check32("abort_busy",   {31'd0, busy_o}, 32'h0);
      check32("abort_result", result_o, 32'h0);
      check32("abort_done",   {31'd0, done_o}, 32'h0);
      rst = 1'b0;
      repeat (40) @(negedge clk);

      // Reset wins over a simultaneous start
      rst     = 1'b1;
      start_i = 1'b1;
      DivOp_i = DIV_DIVU;
      operand1_i = 32'd50;
      operand2_i = 32'd5;
      @(negedge clk);
      rst     = 1'b0;
      start_i = 1'b0;
      check32("rst_prio_busy", {31'd0, busy_o}, 32'h0);
      repeat (40) @(negedge clk);

      // Back-to-back: each start issued the cycle after the previous done_o
      run(DIV_DIVU, 32'd9,  32'd3, 32'd3, 33, "b2b_divu_9_3");
      run(DIV_REMU, 32'd10, 32'd4, 32'd2, 33, "b2b_remu_10_4");
      repeat (5) @(negedge clk);

      check_int("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
